// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the program-counter sequencer.
// Redirect ranking lets a pending redirect be replaced only by a stronger one.
package pc_seq_pkg;

    typedef enum logic [1:0] {
        BOOT,
        FETCH,
        STALLED
    } state_t;

    typedef enum logic [2:0] {
        SEL_SEQ,
        SEL_HOLD,
        SEL_BR,
        SEL_JMP,
        SEL_EXC,
        SEL_PEND
    } sel_t;

    localparam logic [31:0] RESET_PC_DEF   = 32'h0000_0000;
    localparam logic [31:0] EXC_VECTOR_DEF = 32'h0000_0180;
    localparam logic [31:0] ALIGN_MASK     = 32'hFFFF_FFFC;

    // Only fresh redirect sources are ranked; SEL_PEND is already captured.
    function automatic logic [1:0] redirect_rank(input sel_t s);
        case (s)
            SEL_EXC: redirect_rank = 2'd3;
            SEL_BR:  redirect_rank = 2'd2;
            SEL_JMP: redirect_rank = 2'd1;
            default: redirect_rank = 2'd0;
        endcase
    endfunction

    function automatic logic is_redirect(input sel_t s);
        is_redirect = (redirect_rank(s) != 2'd0);
    endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Priority selector for the next program counter; purely combinational.
// Every produced address is word aligned.
module pc_next_sel
    import pc_seq_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
    input  logic [31:0] pc,
    input  logic [31:0] pc_add,
    input  logic        exc,
    input  logic        pend_v,
    input  logic [31:0] pend_tgt,
    input  logic        br,
    input  logic [31:0] br_tgt,
    input  logic        jmp,
    input  logic [31:0] jmp_tgt,
    input  logic        stall,
    output sel_t        sel,
    output logic [31:0] next_pc
);

    always_comb begin
        sel = SEL_SEQ;
        if (exc)         sel = SEL_EXC;
        else if (pend_v) sel = SEL_PEND;
        else if (br)     sel = SEL_BR;
        else if (jmp)    sel = SEL_JMP;
        else if (stall)  sel = SEL_HOLD;
    end

    always_comb begin
        next_pc = pc_add & ALIGN_MASK;
        case (sel)
            SEL_EXC:  next_pc = EXC_VECTOR & ALIGN_MASK;
            SEL_PEND: next_pc = pend_tgt & ALIGN_MASK;
            SEL_BR:   next_pc = br_tgt & ALIGN_MASK;
            SEL_JMP:  next_pc = jmp_tgt & ALIGN_MASK;
            SEL_HOLD: next_pc = pc & ALIGN_MASK;
            default:  next_pc = pc_add & ALIGN_MASK;
        endcase
    end

endmodule

// File: rtl/pc_sequencer.sv
// Architectural PC owner: fetch FSM, PC register, pending-redirect capture and EPC.
// Redirects seen while a fetch is outstanding are parked and applied at completion.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] PCAddResult,
    input  logic        Stall,
    input  logic        BranchTaken,
    input  logic [31:0] BranchTarget,
    input  logic        Jump,
    input  logic [31:0] JumpTarget,
    input  logic        Exception,
    input  logic        ImemReady,
    output logic [31:0] PCResult,
    output logic        ImemReq,
    output logic        FetchValid,
    output logic [31:0] EPC
);

    state_t      state_reg, state_next;
    logic [31:0] pc_reg, pc_next;
    logic [31:0] epc_reg, epc_next;
    logic        pend_v_reg, pend_v_next;
    logic [31:0] pend_tgt_reg, pend_tgt_next;
    sel_t        pend_sel_reg, pend_sel_next;

    logic        waiting;
    sel_t        sel;
    logic [31:0] sel_pc;

    // While waiting, the pending entry is masked so sel reports the freshest redirect.
    assign waiting = (state_reg == FETCH) && !ImemReady;

    pc_next_sel #(
        .EXC_VECTOR (EXC_VECTOR)
    ) u_next_sel (
        .pc       (pc_reg),
        .pc_add   (PCAddResult),
        .exc      (Exception),
        .pend_v   (pend_v_reg && !waiting),
        .pend_tgt (pend_tgt_reg),
        .br       (BranchTaken),
        .br_tgt   (BranchTarget),
        .jmp      (Jump),
        .jmp_tgt  (JumpTarget),
        .stall    (Stall),
        .sel      (sel),
        .next_pc  (sel_pc)
    );

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_reg    <= BOOT;
            pc_reg       <= RESET_PC & ALIGN_MASK;
            epc_reg      <= 32'h0;
            pend_v_reg   <= 1'b0;
            pend_tgt_reg <= 32'h0;
            pend_sel_reg <= SEL_SEQ;
        end else begin
            state_reg    <= state_next;
            pc_reg       <= pc_next;
            epc_reg      <= epc_next;
            pend_v_reg   <= pend_v_next;
            pend_tgt_reg <= pend_tgt_next;
            pend_sel_reg <= pend_sel_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            BOOT:    state_next = FETCH;
            FETCH:   if (ImemReady) state_next = Stall ? STALLED : FETCH;
            STALLED: if (!Stall) state_next = FETCH;
            default: state_next = BOOT;
        endcase
    end

    always_comb begin
        pc_next       = pc_reg;
        pend_v_next   = pend_v_reg;
        pend_tgt_next = pend_tgt_reg;
        pend_sel_next = pend_sel_reg;
        epc_next      = Exception ? pc_reg : epc_reg;
        case (state_reg)
            FETCH: begin
                if (ImemReady) begin
                    pc_next     = sel_pc;
                    pend_v_next = 1'b0;
                end else if (is_redirect(sel) &&
                             (!pend_v_reg || sel == SEL_EXC ||
                              redirect_rank(sel) > redirect_rank(pend_sel_reg))) begin
                    pend_v_next   = 1'b1;
                    pend_tgt_next = sel_pc;
                    pend_sel_next = sel;
                end
            end
            default: begin
                // No fetch in flight: redirects take effect at once.
                if (is_redirect(sel)) pc_next = sel_pc;
            end
        endcase
    end

    always_comb begin
        PCResult   = pc_reg;
        EPC        = epc_reg;
        ImemReq    = (state_reg == FETCH);
        FetchValid = (state_reg == FETCH) && ImemReady &&
                     !(Exception || BranchTaken || Jump || pend_v_reg);
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomized scoreboard bench for pc_sequencer with a cycle-level reference model.
// Directed scenarios run first, then random redirects, stalls, wait states and resets.
module tb_pc_sequencer;

    localparam logic [31:0] RESET_PC   = 32'h0000_0000;
    localparam logic [31:0] EXC_VECTOR = 32'h0000_0180;
    localparam logic [31:0] MASK       = 32'hFFFF_FFFC;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic [31:0] PCAddResult;
    logic        Stall = 1'b0;
    logic        BranchTaken = 1'b0;
    logic [31:0] BranchTarget = 32'h0;
    logic        Jump = 1'b0;
    logic [31:0] JumpTarget = 32'h0;
    logic        Exception = 1'b0;
    logic        ImemReady = 1'b0;
    logic [31:0] PCResult;
    logic        ImemReq;
    logic        FetchValid;
    logic [31:0] EPC;

    always #5 Clk = ~Clk;

    assign PCAddResult = PCResult + 32'd4;

    pc_sequencer #(
        .RESET_PC   (RESET_PC),
        .EXC_VECTOR (EXC_VECTOR)
    ) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .PCAddResult  (PCAddResult),
        .Stall        (Stall),
        .BranchTaken  (BranchTaken),
        .BranchTarget (BranchTarget),
        .Jump         (Jump),
        .JumpTarget   (JumpTarget),
        .Exception    (Exception),
        .ImemReady    (ImemReady),
        .PCResult     (PCResult),
        .ImemReq      (ImemReq),
        .FetchValid   (FetchValid),
        .EPC          (EPC)
    );

    typedef struct {
        logic [31:0] pc;
        logic        req;
        logic        fv;
        logic [31:0] epc;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   txns   = 0;

    // Reference model: phase 0 = boot, 1 = fetching, 2 = stalled.
    int          m_phase;
    logic [31:0] m_pc;
    logic [31:0] m_epc;
    logic        m_pv;
    logic [31:0] m_pt;
    int          m_pr;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_pc    = RESET_PC & MASK;
        m_epc   = 32'h0;
        m_pv    = 1'b0;
        m_pt    = 32'h0;
        m_pr    = 0;
    endtask

    // Drive one cycle at the falling edge, queue the expected outputs,
    // then advance the model across the following rising edge.
    task automatic cyc(input logic rst_n, input logic rdy, input logic stall,
                       input logic br, input logic [31:0] bt,
                       input logic jmp, input logic [31:0] jt, input logic exc);
        exp_t        e;
        int          nr;
        logic [31:0] nt;
        @(negedge Clk);
        Reset = rst_n; ImemReady = rdy; Stall = stall;
        BranchTaken = br; BranchTarget = bt; Jump = jmp; JumpTarget = jt; Exception = exc;
        #1;
        if (!rst_n) begin
            model_reset();
            e.pc = RESET_PC & MASK; e.req = 1'b0; e.fv = 1'b0; e.epc = 32'h0;
            sb_q.push_back(e);
        end else begin
            e.pc  = m_pc;
            e.req = (m_phase == 1);
            e.fv  = (m_phase == 1) && rdy && !(exc || br || jmp || m_pv);
            e.epc = m_epc;
            sb_q.push_back(e);
            nr = 0; nt = 32'h0;
            if (exc)      begin nr = 3; nt = EXC_VECTOR; end
            else if (br)  begin nr = 2; nt = bt; end
            else if (jmp) begin nr = 1; nt = jt; end
            nt = nt & MASK;
            if (exc) m_epc = m_pc;
            if (m_phase == 0) begin
                if (nr != 0) m_pc = nt;
                m_phase = 1;
            end else if (m_phase == 1) begin
                if (rdy) begin
                    if (exc)          m_pc = EXC_VECTOR & MASK;
                    else if (m_pv)    m_pc = m_pt;
                    else if (nr != 0) m_pc = nt;
                    else if (!stall)  m_pc = (m_pc + 32'd4) & MASK;
                    m_pv    = 1'b0;
                    m_phase = stall ? 2 : 1;
                end else if (nr != 0 && (!m_pv || nr == 3 || nr > m_pr)) begin
                    m_pv = 1'b1; m_pt = nt; m_pr = nr;
                end
            end else begin
                if (nr != 0) m_pc = nt;
                m_phase = stall ? 2 : 1;
            end
        end
        #2;
    endtask

    task automatic idle(input logic rdy, input logic stall);
        cyc(1'b1, rdy, stall, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic jump_to(input logic [31:0] t, input logic stall);
        cyc(1'b1, 1'b1, stall, 1'b0, 32'h0, 1'b1, t, 1'b0);
    endtask

    // Monitor: compares whatever the stimulus side queued for this cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge Clk);
            #2;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                txns++;
                check32("sb_pc", PCResult, e.pc);
                check1("sb_req", ImemReq, e.req);
                check1("sb_fetchvalid", FetchValid, e.fv);
                check32("sb_epc", EPC, e.epc);
                $display("txn %0d rst=%b rdy=%b stall=%b br=%b jmp=%b exc=%b pc=%h req=%b fv=%b epc=%h",
                         txns, Reset, ImemReady, Stall, BranchTaken, Jump, Exception,
                         PCResult, ImemReq, FetchValid, EPC);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        repeat (3) cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);

        // Boot cycle, then sequential fetch at one word per cycle.
        idle(1'b1, 1'b0);
        check32("boot_pc", PCResult, 32'h0);
        check1("boot_req", ImemReq, 1'b0);
        idle(1'b1, 1'b0);
        check32("first_fetch_pc", PCResult, 32'h0);
        check1("first_fetch_valid", FetchValid, 1'b1);
        idle(1'b1, 1'b0);
        check32("seq_pc_4", PCResult, 32'h4);
        idle(1'b1, 1'b0);
        idle(1'b1, 1'b0);
        check32("seq_pc_c", PCResult, 32'hC);

        // Branch with unaligned target.
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 32'h47, 1'b0, 32'h0, 1'b0);
        check32("branch_at_pc", PCResult, 32'h10);
        check1("branch_squash", FetchValid, 1'b0);
        idle(1'b1, 1'b0);
        check32("branch_target", PCResult, 32'h44);

        // Jump pulse during an outstanding fetch must be parked.
        jump_to(32'h20, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h100, 1'b0);
        check32("wait_pc_hold", PCResult, 32'h20);
        idle(1'b0, 1'b0);
        idle(1'b0, 1'b0);
        check32("wait_pc_hold2", PCResult, 32'h20);
        idle(1'b1, 1'b0);
        check1("pend_squash", FetchValid, 1'b0);
        idle(1'b1, 1'b0);
        check32("pend_target", PCResult, 32'h100);

        // Stall window.
        jump_to(32'h30, 1'b1);
        idle(1'b1, 1'b1);
        check32("stall_pc", PCResult, 32'h30);
        check1("stall_req", ImemReq, 1'b0);
        idle(1'b1, 1'b1);
        idle(1'b1, 1'b1);
        check1("stall_req3", ImemReq, 1'b0);
        idle(1'b1, 1'b0);
        idle(1'b1, 1'b0);
        check32("resume_pc", PCResult, 32'h30);
        check1("resume_req", ImemReq, 1'b1);
        idle(1'b1, 1'b0);
        check32("resume_next", PCResult, 32'h34);

        // Exception beats a simultaneous branch.
        jump_to(32'h40, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 32'h200, 1'b0, 32'h0, 1'b1);
        idle(1'b1, 1'b0);
        check32("exc_epc", EPC, 32'h40);
        check32("exc_vector", PCResult, 32'h180);

        // Address wrap.
        jump_to(32'hFFFF_FFFC, 1'b0);
        idle(1'b1, 1'b0);
        check32("wrap_top", PCResult, 32'hFFFF_FFFC);
        idle(1'b1, 1'b0);
        check32("wrap_zero", PCResult, 32'h0);

        // Asynchronous reset during an outstanding fetch with a parked jump.
        jump_to(32'h80, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h300, 1'b0);
        check32("pre_reset_pc", PCResult, 32'h80);
        Reset = 1'b0;
        #1;
        check32("async_reset_pc", PCResult, 32'h0);
        check1("async_reset_req", ImemReq, 1'b0);
        model_reset();
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        idle(1'b1, 1'b0);
        idle(1'b1, 1'b0);
        idle(1'b1, 1'b0);
        check32("pend_cleared", PCResult, 32'h4);

        // Random phase.
        for (int i = 0; i < 800; i++) begin
            logic        r_rst, r_rdy, r_stall, r_br, r_jmp, r_exc;
            logic [31:0] r_bt, r_jt;
            r_rst   = ($urandom_range(0, 199) != 0);
            r_rdy   = ($urandom_range(0, 3) != 0);
            r_stall = ($urandom_range(0, 5) == 0);
            r_br    = ($urandom_range(0, 7) == 0);
            r_jmp   = ($urandom_range(0, 7) == 0);
            r_exc   = ($urandom_range(0, 31) == 0);
            r_bt    = $urandom();
            r_jt    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                  : 32'($urandom_range(0, 4095));
            cyc(r_rst, r_rdy, r_stall, r_br, r_bt, r_jmp, r_jt, r_exc);
        end

        repeat (3) @(negedge Clk);
        #3;
        checks++;
        if (sb_q.size() != 0 || txns == 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d left and %0d compared, expected 0 left", sb_q.size(), txns);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Owns the architectural program counter of the 32-bit MIPS core and sequences every instruction fetch.
- Drives PCResult into the existing PC+4 incrementor and takes its PCAddResult back.
- Selects the next PC from sequential, branch, jump or exception-vector sources.
- Handles a ready-based instruction-memory handshake, hazard stalls, and redirects that arrive while a fetch is outstanding.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
EXC_VECTOR, 32'h0000_0180, exception handler entry address

Ports:
Clk  input  1  system clock, rising edge
Reset  input  1  asynchronous, active-low reset
PCAddResult  input  32  PC+4 returned from the incrementor
Stall  input  1  hazard unit hold request
BranchTaken  input  1  branch resolved taken this cycle
BranchTarget  input  32  branch destination
Jump  input  1  j/jal/jr redirect this cycle
JumpTarget  input  32  jump destination
Exception  input  1  trap request
ImemReady  input  1  instruction memory returns the word for PCResult this cycle
PCResult  output  32  current fetch address
ImemReq  output  1  fetch request for PCResult
FetchValid  output  1  fetched word is correct-path and may enter IF/ID
EPC  output  32  PC captured on exception

Behaviour:
- Reset (Reset=0, asynchronous):
  - PCResult=RESET_PC, EPC=0, state=BOOT.
  - ImemReq=0, FetchValid=0, pending-redirect flag PendV=0.
  - Reset asserted mid-fetch aborts the fetch immediately.
- States:
  - BOOT: one cycle after reset release, ImemReq=0, then go to FETCH.
  - FETCH: ImemReq=1, waiting on ImemReady.
  - STALLED: ImemReq=0, PC held.
- Redirect priority (highest first):
  1. Exception → EXC_VECTOR. EPC<=PCResult in the same edge.
  2. PendV → PendTgt.
  3. BranchTaken → BranchTarget.
  4. Jump → JumpTarget.
  5. Stall → hold.
  6. Otherwise → PCAddResult.
- Address alignment: bits [1:0] of every loaded PC are forced to 2'b00. Arithmetic is 32-bit modulo; 32'hFFFF_FFFC + 4 wraps to 0 with no flag.
- FETCH with ImemReady=1:
  - FetchValid=1 only if no redirect source is active and PendV=0. Otherwise FetchValid=0 and the word is squashed.
  - PC updates on that edge per priority; PendV clears.
  - If Stall=1 and no redirect: PC holds and state goes to STALLED.
- FETCH with ImemReady=0:
  - PC holds and FetchValid=0.
  - Any active redirect is captured as PendTgt and PendV=1. A later, higher-priority redirect overwrites it; an Exception always overwrites.
  - Exception is also captured into pending: EPC is written immediately, the vector is applied at completion.
- STALLED:
  - Stall=0 → return to FETCH next cycle with the same PC.
  - A redirect while stalled loads the target immediately, stays STALLED if Stall is still 1, and does not assert ImemReq.
- Simultaneous BranchTaken and Jump: branch wins. A single-cycle pulse of either must never be lost.
- Latency:
  - Sequential fetch: 1 cycle per instruction when ImemReady is held high.
  - Redirect: target appears on PCResult the cycle after the redirect is accepted.

Decomposition:
- Package pc_seq_pkg holds:
  - state enum {BOOT, FETCH, STALLED};
  - next-PC select enum {SEL_SEQ, SEL_HOLD, SEL_BR, SEL_JMP, SEL_EXC, SEL_PEND};
  - RESET_PC / EXC_VECTOR defaults and the alignment mask.
- One combinational sub-module, pc_next_sel, implements the priority select and produces the 32-bit next PC. The FSM, PC register, pending register and EPC stay in pc_sequencer.
- The existing incrementor remains outside and is wired through PCResult/PCAddResult.

Test Plan:
- Reset release with ImemReady=1 and PCAddResult=PC+4: PCResult reads 0 (BOOT, ImemReq=0), then 0, 4, 8, 0xC on successive cycles, with FetchValid=1 from the first FETCH cycle.
- At PC=0x10, BranchTaken=1 with BranchTarget=0x47: that cycle FetchValid=0; next PCResult=0x44.
- At PC=0x20 with ImemReady=0, pulse Jump=1 (JumpTarget=0x100) for one cycle, then ImemReady=1 three cycles later: PC holds 0x20, the completing word is squashed, next PCResult=0x100.
- Stall=1 for 3 cycles at PC=0x30: ImemReq=0 and PCResult=0x30 throughout; after release, fetch resumes at 0x30, then 0x34.
- Exception=1 together with BranchTaken=1 at PC=0x40: EPC=0x40 and next PCResult=0x180.
- Reset driven low mid-FETCH at PC=0x80 between clock edges: PCResult=0 and ImemReq=0 immediately; PendV cleared.
